uart_rx_async: RTL and testbench

UART_RX_ASYNC -- requirements
Module: uart_rx_async

---
 rtl/uart_rx_async.sv | 117 +++++++++++
 tb/tb_uart_rx_async.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_async.sv
// uart_rx_async: 16x-oversampled UART receiver, 7/8 data bits, optional parity; UART_RX_MAJORITY_VOTE_EN enables 2-of-3 bit voting
module uart_rx_async #(
  parameter int CLR_ERR_ON_READ = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  output logic [7:0] rx_byte,
  output logic       rx_ready,
  output logic       rx_busy,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [3:0] samp_cnt, samp_n;
  logic [2:0] bit_cnt, bit_n;
  logic rx_m, rx_s, armed, bitv, decide, load, pbit, pe_ev, fe_ev;
  logic [7:0] shreg, data;
  assign decide  = baud_clock && samp_cnt == 4'd8;
  assign load    = decide && state == STOP;
  assign data    = bit8 ? shreg : {1'b0, shreg[7:1]};
  assign pe_ev   = parity_en && ((^data ^ pbit) != odd_n_even);
  assign fe_ev   = !bitv;
  assign rx_busy = state != IDLE;
`ifdef UART_RX_MAJORITY_VOTE_EN
  logic v6, v7;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      v6 <= 1'b1;
      v7 <= 1'b1;
    end else if (baud_clock && state != IDLE) begin
      if (samp_cnt == 4'd6) v6 <= rx_s;
      if (samp_cnt == 4'd7) v7 <= rx_s;
    end
  assign bitv = (v6 & v7) | (v6 & rx_s) | (v7 & rx_s);
`else
  assign bitv = rx_s;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      samp_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state    <= state_n;
      samp_cnt <= samp_n;
      bit_cnt  <= bit_n;
    end
  always_comb begin
    state_n = state;
    samp_n  = samp_cnt;
    bit_n   = bit_cnt;
    if (baud_clock) begin
      samp_n = samp_cnt + 4'd1;
      case (state)
        IDLE: begin
          samp_n = '0;
          if (!rx_s && armed) state_n = START;
        end
        START:
          if (decide && bitv) begin
            state_n = IDLE;
            samp_n  = '0;
          end else if (samp_cnt == 4'd15) begin
            state_n = DATA;
            bit_n   = '0;
          end
        DATA:
          if (samp_cnt == 4'd15) begin
            bit_n = bit_cnt + 3'd1;
            if (bit_cnt == (bit8 ? 3'd7 : 3'd6)) state_n = parity_en ? PARITY : STOP;
          end
        PARITY: if (samp_cnt == 4'd15) state_n = STOP;
        STOP:
          if (decide) begin
            state_n = IDLE;
            samp_n  = '0;
          end
        default: state_n = IDLE;
      endcase
    end
  end
  // a completed frame always lands in rx_byte; read only clears what no new load re-asserts
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      armed       <= 1'b0;
      shreg       <= '0;
      pbit        <= 1'b0;
      rx_byte     <= '0;
      rx_ready    <= 1'b0;
      overflow    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      rx_m        <= rx;
      rx_s        <= rx_m;
      armed       <= load ? 1'b0 : (baud_clock && rx_s) ? 1'b1 : armed;
      if (decide && state == DATA) shreg <= {bitv, shreg[7:1]};
      if (decide && state == PARITY) pbit <= bitv;
      if (load) rx_byte <= data;
      rx_ready    <= load | (rx_ready & ~read_rx_byte);
      overflow    <= (load & rx_ready & ~read_rx_byte) | (overflow & ~read_rx_byte);
      parity_err  <= CLR_ERR_ON_READ != 0 ? (load & pe_ev) | (parity_err & ~read_rx_byte)
                                          : load ? pe_ev : parity_err;
      framing_err <= CLR_ERR_ON_READ != 0 ? (load & fe_ev) | (framing_err & ~read_rx_byte)
                                          : load ? fe_ev : framing_err;
    end
endmodule

// File: tb/tb_uart_rx_async.sv
// tb_uart_rx_async: frame-level model of the receiver checked every cycle, plus literal spot checks
module tb_uart_rx_async;
  logic clk = 0, reset_n = 0, baud_clock = 0, rx = 1;
  logic bit8 = 1, parity_en = 0, odd_n_even = 0, read_rx_byte = 0;
  logic [7:0] rx_byte;
  logic rx_ready, rx_busy, parity_err, framing_err, overflow;
  int errors = 0, checks = 0;
  logic chk_en = 0;
  logic [7:0] m_byte = 0;
  logic m_ready = 0, m_ovf = 0, m_pe = 0, m_fe = 0, m_busy = 0;

  uart_rx_async dut (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .read_rx_byte(read_rx_byte), .rx_byte(rx_byte), .rx_ready(rx_ready),
    .rx_busy(rx_busy), .parity_err(parity_err), .framing_err(framing_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (chk_en) begin
      chk("byte", rx_byte, m_byte);
      chk("ready", rx_ready, m_ready);
      chk("busy", rx_busy, m_busy);
      chk("parity_err", parity_err, m_pe);
      chk("framing_err", framing_err, m_fe);
      chk("overflow", overflow, m_ovf);
    end

  // one baud tick: line set 3 clks ahead so the synchronizer has settled
  task automatic tick(input logic v, input logic rd);
    rx = v;
    repeat (3) @(posedge clk);
    #1 baud_clock = 1; read_rx_byte = rd;
    @(posedge clk);
    #1 baud_clock = 0; read_rx_byte = 0;
  endtask

  task automatic model_load(input logic [7:0] d, input logic pen, input logic odd,
                            input logic pb, input logic stop, input logic rd);
    logic pe;
    pe = pen && ((^d ^ pb) != odd);
    m_ovf = rd ? 1'b0 : (m_ready ? 1'b1 : m_ovf);
    m_ready = 1;
    m_byte = d;
    m_pe = pe | (m_pe & !rd);
    m_fe = !stop | (m_fe & !rd);
  endtask

  task automatic rd_pulse();
    read_rx_byte = 1;
    @(posedge clk);
    #1 read_rx_byte = 0;
    m_ready = 0; m_ovf = 0; m_pe = 0; m_fe = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic b8, input logic pen, input logic odd,
                      input logic pflip, input logic stop, input logic rd, input int gk);
    logic fr[12];
    logic [7:0] dd;
    logic pb, v;
    int n;
    bit8 = b8; parity_en = pen; odd_n_even = odd;
    dd = b8 ? d : {1'b0, d[6:0]};
    pb = (^dd) ^ odd ^ pflip;
    fr[0] = 0;
    n = b8 ? 8 : 7;
    for (int i = 0; i < n; i++) fr[1 + i] = dd[i];
    n = n + 1;
    if (pen) begin
      fr[n] = pb;
      n = n + 1;
    end
    fr[n] = stop;
    tick(1, 0);
    tick(1, 0);
    for (int k = 0; k <= n; k++)
      for (int s = 0; s < 16; s++) begin
        v = fr[k] ^ (k == gk && s == 8);
        tick(v, rd && k == n && s == 9);
        if (k == 0 && s == 0) m_busy = 1;
        if (k == n && s == 9) begin
          m_busy = 0;
          model_load(dd, pen, odd, pb, stop, rd);
        end
      end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_byte", rx_byte, 8'h00);
    chk("rst_ready", rx_ready, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_flags", {parity_err, framing_err, overflow}, 0);
    reset_n = 1;
    chk_en = 1;
    repeat (3) tick(1, 0);
    send(8'hA5, 1, 0, 0, 0, 1, 0, -1);
    chk("a5_byte", rx_byte, 8'hA5);
    chk("a5_ready", rx_ready, 1);
    chk("a5_flags", {parity_err, framing_err, overflow}, 0);
    rd_pulse();
    chk("a5_read", rx_ready, 0);
    send(8'h3C, 1, 1, 1, 1, 1, 0, -1);
    chk("3c_bad_pe", parity_err, 1);
    chk("3c_byte", rx_byte, 8'h3C);
    rd_pulse();
    send(8'h3C, 1, 1, 1, 0, 1, 0, -1);
    chk("3c_good_pe", parity_err, 0);
    rd_pulse();
    send(8'h55, 0, 1, 0, 0, 1, 0, -1);
    chk("7e1_55", rx_byte, 8'h55);
    send(8'h7F, 0, 1, 0, 0, 0, 0, -1);
    chk("7f_fe", framing_err, 1);
    repeat (20) tick(1, 0);
    chk("7f_fe_sticky", framing_err, 1);
    rd_pulse();
    chk("7f_fe_clr", framing_err, 0);
    send(8'h11, 1, 0, 0, 0, 1, 0, -1);
    send(8'h22, 1, 0, 0, 0, 1, 0, -1);
    chk("ovf_set", overflow, 1);
    chk("ovf_byte", rx_byte, 8'h22);
    rd_pulse();
    chk("ovf_clr", overflow, 0);
    send(8'h44, 1, 0, 0, 0, 1, 0, -1);
    send(8'h66, 1, 0, 0, 0, 1, 1, -1);
    chk("coinc_ovf", overflow, 0);
    chk("coinc_ready", rx_ready, 1);
    rd_pulse();
    tick(1, 0);
    tick(1, 0);
    for (int i = 0; i < 16; i++) begin
      tick(i < 4 ? 1'b0 : 1'b1, 0);
      if (i == 0) m_busy = 1;
      if (i == 9) m_busy = 0;
    end
    chk("glitch_ready", rx_ready, 0);
    chk("glitch_busy", rx_busy, 0);
    send(8'h5A, 1, 0, 0, 0, 1, 0, 3);
    chk("flip_byte", rx_byte, 8'h5A);
    rd_pulse();
    send(8'h00, 1, 0, 0, 0, 0, 0, -1);
    repeat (40) tick(0, 0);
    chk("brk_byte", rx_byte, 8'h00);
    chk("brk_fe", framing_err, 1);
    chk("brk_busy", rx_busy, 0);
    bit8 = 1; parity_en = 0;
    tick(1, 0);
    tick(1, 0);
    for (int k = 0; k < 4; k++)
      for (int s = 0; s < 16; s++) begin
        logic [7:0] f0;
        f0 = 8'hF0;
        tick(k == 0 ? 1'b0 : f0[k - 1], 0);
        if (k == 0 && s == 0) m_busy = 1;
      end
    chk_en = 0;
    reset_n = 0;
    #2;
    chk("mrst_byte", rx_byte, 8'h00);
    chk("mrst_ready", rx_ready, 0);
    chk("mrst_busy", rx_busy, 0);
    chk("mrst_flags", {parity_err, framing_err, overflow}, 0);
    m_byte = 0; m_ready = 0; m_ovf = 0; m_pe = 0; m_fe = 0; m_busy = 0;
    @(posedge clk);
    #1 reset_n = 1;
    chk_en = 1;
    repeat (20) tick(0, 0);
    chk("mrst_nostart", rx_busy, 0);
    send(8'h81, 1, 0, 0, 0, 1, 0, -1);
    chk("81_byte", rx_byte, 8'h81);
    chk("81_ready", rx_ready, 1);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
